io_switch_reader: RTL and testbench

Read-side IO responder for the CPU's memory-mapped switch and cycle registers. It synchronizes and debounces four raw front-panel push switches, latches each press into a sticky event flag, and keeps a 32-bit cycle counter. It answers CPU IO loads at the sort-start, CE, CP, CH and cycle addresses. It is the input-direction counterpart of the LED and sort-result output registers, and sits beside them on the CPU data-memory/IO bus.

---
 rtl/io_switch_reader.sv | 116 +++++++++++
 tb/tb_io_switch_reader.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_switch_reader.sv
// io_switch_reader: read-side IO responder for the front-panel switches and
// the free-running cycle register. Each raw switch is synchronized, debounced
// and turned into a sticky press flag that a CPU load clears.
// Build option: define IO_SWITCH_DEBOUNCE_EN to include the per-switch
// debounce counters; without it a switch level is accepted one edge after
// it reaches the second synchronizer flop.
module io_switch_reader #(
  parameter int                     COUNT_WIDTH    = 28,
  parameter logic [COUNT_WIDTH-1:0] DEBOUNCE_COUNT = 28'h3000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  swIn,
  input  logic        sortFinish,
  input  logic [15:0] dataAddr,
  input  logic        rdEnable,
  output logic [31:0] rdData,
  output logic [3:0]  swLevel
);

  logic [3:0]  sync1_q, sync2_q;
  logic [3:0]  stable_q, stable_d;
  logic [3:0]  stable_prev_q;
  logic [3:0]  flag_q, flag_d;
  logic [31:0] cycle_q, cycle_d;
  logic [3:0]  clr_flag;
  logic        io_hit;
  logic [4:0]  io_idx;

  // Address bits outside the decoded window, including the byte bit, are don't-care.
  logic unused_addr;
  assign unused_addr = ^{dataAddr[14:6], dataAddr[0]};

  assign io_hit  = rdEnable & dataAddr[15];
  assign io_idx  = dataAddr[5:1];
  assign swLevel = stable_q;

`ifdef IO_SWITCH_DEBOUNCE_EN
  logic [COUNT_WIDTH-1:0] cnt_q [4];
  logic [COUNT_WIDTH-1:0] cnt_d [4];

  // Accept a new level only after it has disagreed with the stable level for DEBOUNCE_COUNT edges.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == DEBOUNCE_COUNT - COUNT_WIDTH'(1)) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + COUNT_WIDTH'(1);
        end
      end
    end
  end

  // Debounce counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^DEBOUNCE_COUNT;

  // No filtering: the synchronized level is taken directly.
  always_comb begin
    stable_d = sync2_q;
  end
`endif

  // Load decode; a hit on a flag address also requests that flag's clear.
  always_comb begin
    rdData   = '0;
    clr_flag = '0;
    if (io_hit) begin
      case (io_idx)
        5'h10, 5'h11, 5'h12, 5'h13: begin
          rdData                = {31'b0, flag_q[io_idx[1:0]]};
          clr_flag[io_idx[1:0]] = 1'b1;
        end
        5'h14:   rdData = cycle_q;
        default: rdData = '0;
      endcase
    end
  end

  // Flag and cycle next state; a rising stable level beats a same-edge clear.
  always_comb begin
    flag_d  = (flag_q & ~clr_flag) | (stable_q & ~stable_prev_q);
    cycle_d = sortFinish ? cycle_q : cycle_q + 32'd1;
  end

  // Synchronizer, stable level, flag and cycle registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      stable_q      <= '0;
      stable_prev_q <= '0;
      flag_q        <= '0;
      cycle_q       <= '0;
    end else begin
      sync1_q       <= swIn;
      sync2_q       <= sync1_q;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      flag_q        <= flag_d;
      cycle_q       <= cycle_d;
    end
  end

endmodule

// File: tb/tb_io_switch_reader.sv
// Self-checking bench for io_switch_reader with a behavioural switch/flag/cycle model.
module tb_io_switch_reader;

`ifdef IO_SWITCH_DEBOUNCE_EN
  localparam int EFF_D = 4;
`else
  localparam int EFF_D = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  swIn;
  logic        sortFinish;
  logic [15:0] dataAddr;
  logic        rdEnable;
  logic [31:0] rdData;
  logic [3:0]  swLevel;

  int n_checks = 0;
  int n_errors = 0;

  io_switch_reader #(.COUNT_WIDTH(28), .DEBOUNCE_COUNT(28'd4)) dut (
    .clk(clk), .rst(rst), .swIn(swIn), .sortFinish(sortFinish),
    .dataAddr(dataAddr), .rdEnable(rdEnable), .rdData(rdData), .swLevel(swLevel)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // A switch's accepted level follows its twice-registered input once that
  // input has disagreed with the accepted level for EFF_D consecutive edges.
  logic [3:0]  m_s1, m_s2, m_level, m_prev, m_flag;
  int unsigned m_run [4];
  logic [31:0] m_cycle;
  logic [31:0] cyc_bias;

  function automatic logic [3:0] clear_mask(input logic en, input logic [15:0] a);
    logic [3:0] m;
    m = 4'b0;
    if (en && a[15] && a[5:1] >= 5'h10 && a[5:1] <= 5'h13) m[a[2:1]] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] exp_rd(input logic en, input logic [15:0] a);
    if (!(en && a[15])) return 32'd0;
    case (a[5:1])
      5'h10: return {31'd0, m_flag[0]};
      5'h11: return {31'd0, m_flag[1]};
      5'h12: return {31'd0, m_flag[2]};
      5'h13: return {31'd0, m_flag[3]};
      5'h14: return m_cycle + cyc_bias;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_s1 <= '0; m_s2 <= '0; m_level <= '0; m_prev <= '0; m_flag <= '0;
      m_cycle <= '0;
      for (int i = 0; i < 4; i++) m_run[i] <= 0;
    end else begin
      m_flag <= (m_flag & ~clear_mask(rdEnable, dataAddr)) | (m_level & ~m_prev);
      m_prev <= m_level;
      for (int i = 0; i < 4; i++) begin
        if (m_s2[i] != m_level[i]) begin
          if (m_run[i] + 1 >= EFF_D) begin
            m_level[i] <= m_s2[i];
            m_run[i]   <= 0;
          end else begin
            m_run[i] <= m_run[i] + 1;
          end
        end else begin
          m_run[i] <= 0;
        end
      end
      m_s2 <= m_s1;
      m_s1 <= swIn;
      if (!sortFinish) m_cycle <= m_cycle + 32'd1;
    end
  end

  // ---------------- helpers ----------------
  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic load(input logic [15:0] a);
    rdEnable = 1'b1;
    dataAddr = a;
    #1;
  endtask

  task automatic idle();
    rdEnable = 1'b0;
    dataAddr = 16'h0000;
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; swIn = '0; sortFinish = 1'b0; rdEnable = 1'b0; dataAddr = '0; cyc_bias = '0;
    #12;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (swLevel !== 4'b0) begin n_errors++; $display("FAIL reset_swlevel: got %0h expected 0", swLevel); end
    n_checks++;
    if (rdData !== 32'd0) begin n_errors++; $display("FAIL reset_nohit: got %0h expected 0", rdData); end
    for (int i = 0; i < 4; i++) begin
      load(16'h8020 + 16'(2 * i));
      n_checks++;
      if (rdData !== 32'd0) begin n_errors++; $display("FAIL reset_flag%0d: got %0h expected 0", i, rdData); end
      step();
    end
    idle();
    step(6);
    load(16'h8028);
    n_checks++;
    if (rdData !== 32'd10) begin n_errors++; $display("FAIL reset_cycle10: got %0d expected 10", rdData); end
    idle();
  endtask

  task automatic test_press();
    swIn[0] = 1'b1;
    for (int k = 0; k <= 1 + EFF_D; k++) begin
      step();
      n_checks++;
      if (swLevel[0] !== ((k >= 1 + EFF_D) ? 1'b1 : 1'b0)) begin
        n_errors++; $display("FAIL press_level_edge%0d: got %0b expected %0b", k, swLevel[0], (k >= 1 + EFF_D));
      end
    end
    step();
    load(16'h8020);
    n_checks++;
    if (rdData !== 32'd1) begin n_errors++; $display("FAIL press_flag_set: got %0h expected 1", rdData); end
    step();
    n_checks++;
    if (rdData !== 32'd0) begin n_errors++; $display("FAIL press_flag_clear: got %0h expected 0", rdData); end
    idle();
    swIn[0] = 1'b0;
    step(EFF_D + 4);
  endtask

  task automatic test_glitch();
    swIn[2] = 1'b1;
    step(3);
    swIn[2] = 1'b0;
    for (int k = 0; k < EFF_D + 4; k++) begin
      step();
      n_checks++;
      if (swLevel !== m_level) begin n_errors++; $display("FAIL glitch_level: got %0h expected %0h", swLevel, m_level); end
    end
    load(16'h8024);
    n_checks++;
    if (rdData !== exp_rd(1'b1, 16'h8024)) begin
      n_errors++; $display("FAIL glitch_flag: got %0h expected %0h", rdData, exp_rd(1'b1, 16'h8024));
    end
`ifdef IO_SWITCH_DEBOUNCE_EN
    n_checks++;
    if (rdData !== 32'd0) begin n_errors++; $display("FAIL glitch_flag_const: got %0h expected 0", rdData); end
`endif
    step();
    idle();
  endtask

  task automatic test_coincide();
    swIn[1] = 1'b1;
    step(EFF_D + 3);
    swIn[1] = 1'b0;
    step(EFF_D + 4);
    swIn[1] = 1'b1;
    step(2 + EFF_D);
    load(16'h8022);
    n_checks++;
    if (rdData !== 32'd1) begin n_errors++; $display("FAIL coincide_pre: got %0h expected 1", rdData); end
    step();
    n_checks++;
    if (rdData !== 32'd1) begin n_errors++; $display("FAIL coincide_set_wins: got %0h expected 1", rdData); end
    step();
    n_checks++;
    if (rdData !== 32'd0) begin n_errors++; $display("FAIL coincide_cleared: got %0h expected 0", rdData); end
    idle();
    swIn[1] = 1'b0;
    step(EFF_D + 4);
  endtask

  task automatic test_cycle_wrap();
    logic [31:0] held;
    force dut.cycle_q = 32'hFFFF_FFFE;
    cyc_bias = 32'hFFFF_FFFE - m_cycle;
    #1;
    release dut.cycle_q;
    load(16'h8028);
    n_checks++;
    if (rdData !== 32'hFFFF_FFFE) begin n_errors++; $display("FAIL cycle_forced: got %0h expected fffffffe", rdData); end
    step();
    n_checks++;
    if (rdData !== 32'hFFFF_FFFF) begin n_errors++; $display("FAIL cycle_max: got %0h expected ffffffff", rdData); end
    step();
    n_checks++;
    if (rdData !== 32'd0) begin n_errors++; $display("FAIL cycle_wrap: got %0h expected 0", rdData); end
    step();
    sortFinish = 1'b1;
    #1;
    held = exp_rd(1'b1, 16'h8028);
    for (int k = 0; k < 3; k++) begin
      step();
      n_checks++;
      if (rdData !== held || rdData !== 32'd1) begin
        n_errors++; $display("FAIL cycle_hold: got %0h expected 1", rdData);
      end
    end
    load(16'h802A);
    n_checks++;
    if (rdData !== 32'd0) begin n_errors++; $display("FAIL addr_802a: got %0h expected 0", rdData); end
    load(16'h0028);
    n_checks++;
    if (rdData !== 32'd0) begin n_errors++; $display("FAIL addr_0028: got %0h expected 0", rdData); end
    rdEnable = 1'b0; dataAddr = 16'h8028; #1;
    n_checks++;
    if (rdData !== 32'd0) begin n_errors++; $display("FAIL no_rden: got %0h expected 0", rdData); end
    sortFinish = 1'b0;
    idle();
  endtask

  task automatic test_reset_mid();
    swIn[3] = 1'b1;
    step(4);
    rst = 1'b1;
    cyc_bias = '0;
    #1;
    n_checks++;
    if (swLevel !== 4'b0) begin n_errors++; $display("FAIL midrst_level: got %0h expected 0", swLevel); end
`ifdef IO_SWITCH_DEBOUNCE_EN
    n_checks++;
    if (dut.cnt_q[3] !== 28'd0) begin n_errors++; $display("FAIL midrst_counter: got %0h expected 0", dut.cnt_q[3]); end
`endif
    step();
    rst = 1'b0;
    swIn[3] = 1'b0;
    step(EFF_D + 5);
    n_checks++;
    if (swLevel !== 4'b0) begin n_errors++; $display("FAIL midrst_after: got %0h expected 0", swLevel); end
    load(16'h8026);
    n_checks++;
    if (rdData !== 32'd0) begin n_errors++; $display("FAIL midrst_flag: got %0h expected 0", rdData); end
    step();
    idle();
  endtask

  task automatic test_random();
    int hold [4];
    logic [15:0] addrs [8];
    logic [15:0] a;
    logic [31:0] e;
    addrs[0] = 16'h8020; addrs[1] = 16'h8022; addrs[2] = 16'h8024; addrs[3] = 16'h8026;
    addrs[4] = 16'h8028; addrs[5] = 16'h802A; addrs[6] = 16'h0020; addrs[7] = 16'h8021;
    for (int i = 0; i < 4; i++) hold[i] = 1;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++) begin
        hold[i]--;
        if (hold[i] <= 0) begin
          swIn[i] = 1'($urandom_range(0, 1));
          hold[i] = int'($urandom_range(1, 2 * EFF_D + 3));
        end
      end
      sortFinish = ($urandom_range(0, 7) == 0);
      rdEnable   = ($urandom_range(0, 2) != 0);
      a = ($urandom_range(0, 9) == 0) ? 16'($urandom) : addrs[$urandom_range(0, 7)];
      dataAddr   = a;
      #1;
      e = exp_rd(rdEnable, dataAddr);
      n_checks++;
      if (rdData !== e) begin n_errors++; $display("FAIL rand_rd[%0d] addr %0h: got %0h expected %0h", c, a, rdData, e); end
      n_checks++;
      if (swLevel !== m_level) begin n_errors++; $display("FAIL rand_level[%0d]: got %0h expected %0h", c, swLevel, m_level); end
      step();
    end
    idle();
    swIn = '0;
    sortFinish = 1'b0;
    step(EFF_D + 4);
  endtask

  initial begin
    test_reset();
    test_press();
    test_glitch();
    test_coincide();
    test_cycle_wrap();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
